// File: rtl/aes_pkg.sv
// Shared AES-128 constants and types: round constants, forward S-box,
// and the key-scheduler FSM state encoding.
package aes_pkg;

  localparam int NR = 10;

  typedef logic [31:0] aes_word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } ks_state_t;

  // Entry 0 is unused; rounds 1..10 index directly.
  localparam logic [7:0] RCON [0:10] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Out-of-range rounds map to zero so a stray index can never alias a real Rcon.
  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 1; i <= NR; i++) begin
      if (r == 4'(i)) v = RCON[i];
    end
    return v;
  endfunction

  function automatic aes_word_t sub_word(input aes_word_t w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion step: derives round key r from round key r-1.
// Purely combinational; four S-box lookups via sub_word.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] k,
  input  logic [3:0]   r,
  output logic [127:0] k_next
);

  aes_word_t w0, w1, w2, w3, t, w4, w5, w6, w7;

  always_comb begin
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon_of(r), 24'h0};
    w4 = w0 ^ t;
    w5 = w4 ^ w1;
    w6 = w5 ^ w2;
    w7 = w6 ^ w3;
    k_next = {w4, w5, w6, w7};
  end

endmodule

// File: rtl/aes_key_scheduler.sv
// AES-128 round-key controller: accepts a cipher key, expands all round keys
// one per cycle into a local register file, and serves reads with 1-cycle latency.
module aes_key_scheduler #(
  parameter int NR = 10
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               key_valid,
  input  logic [127:0]       key_in,
  output logic               key_ready,
  output logic               busy,
  output logic               keys_ready,
  output logic               done,
  input  logic               rk_req,
  input  logic [3:0]         rk_idx,
  output logic               rk_valid,
  output logic [127:0]       rk_key,
  output logic               rk_miss,
  output aes_pkg::ks_state_t dbg_state
);

  import aes_pkg::*;

  localparam logic [3:0] LAST = 4'(NR);

  ks_state_t    state_q, state_d;
  logic [3:0]   round_q;
  logic [127:0] cur_q;
  logic [127:0] rk_q [0:NR];
  logic [127:0] nxt;
  logic [127:0] rd_key;
  logic         accept;
  logic         rd_ok;
  logic         done_q;

  aes_key_step u_step (
    .k      (cur_q),
    .r      (round_q),
    .k_next (nxt)
  );

  // Handshake: a key transfers on any rising edge where key_valid && key_ready;
  // key_ready is low only while expanding, so the source must hold key_in then.
  always_comb begin
    state_d    = state_q;
    key_ready  = 1'b1;
    busy       = 1'b0;
    keys_ready = 1'b0;
    case (state_q)
      IDLE:    if (key_valid) state_d = EXPAND;
      EXPAND: begin
        key_ready = 1'b0;
        busy      = 1'b1;
        if (round_q == LAST) state_d = READY;
      end
      READY: begin
        keys_ready = 1'b1;
        if (key_valid) state_d = EXPAND;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = key_valid && key_ready;
  assign rd_ok  = rk_req && keys_ready && (rk_idx <= LAST);

  always_comb begin
    rd_key = '0;
    for (int i = 0; i <= NR; i++) begin
      if (rk_idx == 4'(i)) rd_key = rk_q[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      round_q  <= '0;
      cur_q    <= '0;
      done_q   <= 1'b0;
      rk_valid <= 1'b0;
      rk_miss  <= 1'b0;
      rk_key   <= '0;
      for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == EXPAND) && (round_q == LAST);
      if (accept) begin
        rk_q[0] <= key_in;
        cur_q   <= key_in;
        round_q <= 4'd1;
      end else if (state_q == EXPAND) begin
        for (int i = 1; i <= NR; i++) begin
          if (round_q == 4'(i)) rk_q[i] <= nxt;
        end
        cur_q <= nxt;
        // Parks at the last round rather than overrunning the register file.
        if (round_q != LAST) round_q <= round_q + 4'd1;
      end
      // Read samples pre-edge state, so a same-cycle rekey still returns old keys.
      rk_valid <= rd_ok;
      rk_miss  <= rk_req && !rd_ok;
      if (rd_ok) rk_key <= rd_key;
    end
  end

  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_aes_key_scheduler.sv
// Directed bench for aes_key_scheduler: FIPS-197 and all-zero key schedules,
// queue-based read scoreboard, rekey/hold/reset corner cases.
module tb_aes_key_scheduler;

  import aes_pkg::*;

  logic         CLK;
  logic         RST;
  logic         key_valid;
  logic [127:0] key_in;
  logic         key_ready;
  logic         busy;
  logic         keys_ready;
  logic         done;
  logic         rk_req;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic [127:0] rk_key;
  logic         rk_miss;
  ks_state_t    dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  // Bit 128 set means the response must be a miss carrying the held key.
  logic [128:0] exp_q[$];
  logic [127:0] last_key;

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_Z = 128'h0;

  logic [127:0] a_rk [0:10];
  logic [127:0] z_rk1, z_rk10;

  aes_key_scheduler #(.NR(10)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .key_valid  (key_valid),
    .key_in     (key_in),
    .key_ready  (key_ready),
    .busy       (busy),
    .keys_ready (keys_ready),
    .done       (done),
    .rk_req     (rk_req),
    .rk_idx     (rk_idx),
    .rk_valid   (rk_valid),
    .rk_key     (rk_key),
    .rk_miss    (rk_miss),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic read(input logic [3:0] idx, input logic miss, input logic [127:0] k);
    rk_req = 1'b1;
    rk_idx = idx;
    if (miss) exp_q.push_back({1'b1, last_key});
    else begin
      exp_q.push_back({1'b0, k});
      last_key = k;
    end
    @(negedge CLK);
  endtask

  // Entered at the first negedge after the accepting edge; optionally issues
  // one (rejected) read at expansion cycle req_at.
  task automatic wait_done(input int req_at, input string tag);
    int n;
    int nb;
    n  = 1;
    nb = 0;
    while (!done && n < 30) begin
      if (busy) nb++;
      if (n == req_at) begin
        check({tag, "_key_ready_busy"}, 128'(key_ready), 128'(0));
        rk_req = 1'b1;
        rk_idx = 4'd0;
        exp_q.push_back({1'b1, last_key});
      end else begin
        rk_req = 1'b0;
      end
      @(negedge CLK);
      n++;
    end
    rk_req = 1'b0;
    check({tag, "_done_cycle"}, 128'(n), 128'(11));
    check({tag, "_busy_cycles"}, 128'(nb), 128'(10));
    check({tag, "_keys_ready_at_done"}, 128'(keys_ready), 128'(1));
  endtask

  // Scoreboard monitor
  always @(negedge CLK) begin
    logic [128:0] e;
    if (rk_valid || rk_miss) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rk_unexpected: valid=%0b miss=%0b key=%h with no request pending",
                 rk_valid, rk_miss, rk_key);
      end else begin
        e = exp_q.pop_front();
        if (rk_valid !== !e[128] || rk_miss !== e[128] || rk_key !== e[127:0]) begin
          n_bad++;
          $display("FAIL rk_resp: got valid=%0b miss=%0b key=%h expected valid=%0b miss=%0b key=%h",
                   rk_valid, rk_miss, rk_key, !e[128], e[128], e[127:0]);
        end
      end
    end
  end

  initial begin
    a_rk[0]  = KEY_A;
    a_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    a_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    a_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    a_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    a_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    a_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    a_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    a_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    a_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    a_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    z_rk1    = 128'h62636363626363636263636362636363;
    z_rk10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    RST       = 1'b1;
    key_valid = 1'b0;
    key_in    = '0;
    rk_req    = 1'b0;
    rk_idx    = '0;
    last_key  = '0;
    repeat (3) @(negedge CLK);

    check("rst_key_ready", 128'(key_ready), 128'(1));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_keys_ready", 128'(keys_ready), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_rk_valid", 128'(rk_valid), 128'(0));
    check("rst_rk_miss", 128'(rk_miss), 128'(0));
    check("rst_rk_key", rk_key, 128'(0));
    check("rst_state", 128'(dbg_state), 128'(IDLE));
    RST = 1'b0;

    // Read before any key exists
    read(4'd0, 1'b1, '0);
    rk_req = 1'b0;

    // FIPS-197 expansion with a rejected read mid-expansion
    key_valid = 1'b1;
    key_in    = KEY_A;
    @(negedge CLK);
    key_valid = 1'b0;
    wait_done(3, "fips");
    @(negedge CLK);
    check("done_one_cycle", 128'(done), 128'(0));
    check("keys_ready_hold", 128'(keys_ready), 128'(1));

    read(4'd0, 1'b0, a_rk[0]);
    read(4'd1, 1'b0, a_rk[1]);
    read(4'd10, 1'b0, a_rk[10]);
    rk_req = 1'b0;
    @(negedge CLK);

    // Back-to-back reverse reads, then out-of-range indices
    for (int i = 10; i >= 0; i--) read(4'(i), 1'b0, a_rk[i]);
    read(4'd11, 1'b1, '0);
    read(4'd15, 1'b1, '0);
    read(4'd5, 1'b0, a_rk[5]);
    rk_req = 1'b0;
    @(negedge CLK);

    // Key held valid across an expansion: second key accepted on READY entry
    key_valid = 1'b1;
    key_in    = KEY_A;
    @(negedge CLK);
    check("rekey_keys_ready_drop", 128'(keys_ready), 128'(0));
    key_in = KEY_Z;
    wait_done(4, "hold");
    @(negedge CLK);
    key_valid = 1'b0;
    check("hold_accepted_busy", 128'(busy), 128'(1));
    check("hold_done_low", 128'(done), 128'(0));
    wait_done(0, "zero");
    read(4'd10, 1'b0, z_rk10);
    read(4'd1, 1'b0, z_rk1);
    read(4'd0, 1'b0, KEY_Z);
    rk_req = 1'b0;
    @(negedge CLK);

    // Rekey with a same-cycle read: old round-10 key returned
    key_valid = 1'b1;
    key_in    = KEY_A;
    read(4'd10, 1'b0, z_rk10);
    key_valid = 1'b0;
    rk_req    = 1'b0;
    check("rekey_read_keys_ready", 128'(keys_ready), 128'(0));
    check("rekey_read_busy", 128'(busy), 128'(1));
    wait_done(0, "rekey");
    read(4'd10, 1'b0, a_rk[10]);
    read(4'd3, 1'b0, a_rk[3]);
    rk_req = 1'b0;
    @(negedge CLK);

    // Reset mid-expansion
    key_valid = 1'b1;
    key_in    = KEY_Z;
    @(negedge CLK);
    key_valid = 1'b0;
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_keys_ready", 128'(keys_ready), 128'(0));
    check("midrst_key_ready", 128'(key_ready), 128'(1));
    check("midrst_rk_key", rk_key, 128'(0));
    check("midrst_state", 128'(dbg_state), 128'(IDLE));
    RST      = 1'b0;
    last_key = '0;
    read(4'd10, 1'b1, '0);
    read(4'd0, 1'b1, '0);
    rk_req = 1'b0;
    repeat (3) @(negedge CLK);

    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
